// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-stated data-memory responder.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        lu;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_if.sv
// Data-memory bus between the core (master) and dmem_responder (slave).
interface dmem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_ready;
  logic        access_err;

  modport master (
    output mem_read, mem_write, addr, size, load_unsigned, write_data,
    input  read_data, mem_ready, access_err
  );

  modport slave (
    input  mem_read, mem_write, addr, size, load_unsigned, write_data,
    output read_data, mem_ready, access_err
  );
endinterface

// File: rtl/dmem_load_align.sv
// Load lane select: moves the addressed byte/half to the LSBs and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_data = i_word;
    case (i_size)
      SIZE_B:  o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_H:  o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data RAM responder with byte/half/word access and alignment/range checking.
// Optional: DMEM_CYCLE_COUNTER_EN maps a free-running cycle counter at BASE_ADDR+DEPTH_WORDS*4.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int                IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0]       RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam bit                HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(HAS_WAIT ? WAIT_STATES - 1 : 0);

  state_t            r_state, w_state_next;
  logic [WAIT_W-1:0] r_cnt, w_cnt_next;
  req_t              r_req, w_req;
  logic [31:0]       r_mem [DEPTH_WORDS];
  logic [31:0]       r_mem_q;
  logic [31:0]       w_offset, w_wdata_sh, w_word, w_load;
  logic [IDX_W-1:0]  w_idx;
  logic [3:0]        w_be;
  logic              w_req_valid, w_in_ram, w_is_ctr, w_misalign, w_err, w_enter_resp;

  assign w_req_valid = bus.mem_read | bus.mem_write;

  // In IDLE the live bus is decoded so a zero-wait request can commit on its sampling edge.
  always_comb begin
    w_req = r_req;
    if (r_state == IDLE) begin
      w_req.rd    = bus.mem_read;
      w_req.wr    = bus.mem_write;
      w_req.addr  = bus.addr;
      w_req.size  = bus.size;
      w_req.lu    = bus.load_unsigned;
      w_req.wdata = bus.write_data;
    end
  end

  assign w_offset   = w_req.addr - BASE_ADDR;
  assign w_in_ram   = (w_offset < RAM_BYTES);
  assign w_idx      = w_offset[IDX_W+1:2];
  assign w_misalign = ((w_req.size == SIZE_H) && w_req.addr[0]) ||
                      ((w_req.size == SIZE_W) && (w_req.addr[1:0] != 2'b00));
  assign w_err      = (w_req.rd & w_req.wr) | (w_req.size == 2'b11) | w_misalign |
                      ~(w_in_ram | w_is_ctr);
  assign w_wdata_sh = w_req.wdata << {w_req.addr[1:0], 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign w_be[gi] = (w_req.size == SIZE_W) ||
                        ((w_req.size == SIZE_H) && (w_req.addr[1] == LANE[1])) ||
                        ((w_req.size == SIZE_B) && (w_req.addr[1:0] == LANE));
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req_valid) begin
          if (HAS_WAIT) begin
            w_state_next = WAIT;
            w_cnt_next   = WAIT_INIT;
          end else begin
            w_state_next = RESP;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_state_next = RESP;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if ((r_state == IDLE) && w_req_valid) r_req <= w_req;
    end
  end

  // RAM: registered read and byte-lane write share the RESP-entry edge; a request never does both.
  always_ff @(posedge clk) begin
    if (w_enter_resp) r_mem_q <= r_mem[w_idx];
    if (w_enter_resp && w_req.wr && !w_err && !w_is_ctr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycles, r_ctr_q;

  assign w_is_ctr = (w_offset[31:2] == 30'(DEPTH_WORDS));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles <= '0;
      r_ctr_q  <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_enter_resp) r_ctr_q <= r_cycles;
    end
  end

  assign w_word = w_is_ctr ? r_ctr_q : r_mem_q;
`else
  assign w_is_ctr = 1'b0;
  assign w_word   = r_mem_q;
`endif

  dmem_load_align u_load_align (
    .i_word     (w_word),
    .i_offset   (r_req.addr[1:0]),
    .i_size     (r_req.size),
    .i_unsigned (r_req.lu),
    .o_data     (w_load)
  );

  assign bus.mem_ready  = (r_state == RESP);
  assign bus.access_err = (r_state == RESP) && w_err;
  assign bus.read_data  = ((r_state == RESP) && !w_err && r_req.rd) ? w_load : 32'h0;

endmodule
